// File: rtl/multi_port_mem_arbiter_if.sv
// Signal bundle between the channel masters, multi_port_mem_arbiter and the shared bus port.
// The master modport is the arbiter's view (it masters the bus); slave is the environment's view.
interface multi_port_mem_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]            req_ren;
   logic [NUM_CH-1:0]            req_wen;
   logic [NUM_CH*ADDR_W-1:0]     req_addr;
   logic [NUM_CH*DATA_W-1:0]     req_wdata;
   logic [NUM_CH*(DATA_W/8)-1:0] req_byte_en;
   logic [NUM_CH-1:0]            req_busy;
   logic [DATA_W-1:0]            req_rdata;

   logic                         out_ren;
   logic                         out_wen;
   logic [ADDR_W-1:0]            out_addr;
   logic [DATA_W-1:0]            out_wdata;
   logic [DATA_W/8-1:0]          out_byte_en;
   logic                         out_busy;
   logic [DATA_W-1:0]            out_rdata;

   modport master (
      input  req_ren, req_wen, req_addr, req_wdata, req_byte_en,
      output req_busy, req_rdata,
      output out_ren, out_wen, out_addr, out_wdata, out_byte_en,
      input  out_busy, out_rdata
   );

   modport slave (
      output req_ren, req_wen, req_addr, req_wdata, req_byte_en,
      input  req_busy, req_rdata,
      input  out_ren, out_wen, out_addr, out_wdata, out_byte_en,
      output out_busy, out_rdata
   );
endinterface

// File: rtl/multi_port_mem_arbiter.sv
// N-channel arbiter onto one generic-bus port; each grant is held through a REQ/WAIT transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise channel 0 has fixed top priority.
module multi_port_mem_arbiter #(
   parameter int NUM_CH        = 2,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic                     CLK,
   input  logic                     nRST,
   multi_port_mem_arbiter_if.master mif
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BE_W  = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  winner;
   logic [NUM_CH-1:0] active;
   logic              any_active;

   function automatic logic [DATA_W-1:0] swap(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      for (int b = 0; b < BE_W; b++) r[b*8 +: 8] = d[(BE_W-1-b)*8 +: 8];
      return LITTLE_ENDIAN ? r : d;
   endfunction

   assign active     = mif.req_ren | mif.req_wen;
   assign any_active = |active;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
      int s = int'(base) + k;
      if (s >= NUM_CH) s -= NUM_CH;
      return IDX_W'(s);
   endfunction

   // Scanning downward leaves the first active channel at or above rr_ptr as the winner.
   always_comb begin
      winner = rr_ptr_q;
      for (int k = NUM_CH-1; k >= 0; k--)
         if (active[wrap_add(rr_ptr_q, k)]) winner = wrap_add(rr_ptr_q, k);
   end

   assign rr_ptr_d = (state_q == IDLE && any_active) ? wrap_add(winner, 1) : rr_ptr_q;

   always_ff @(posedge CLK) begin
      if (!nRST) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (active[i]) winner = IDX_W'(i);
   end
`endif

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path leaves a latch.
      state_d         = state_q;
      grant_d         = grant_q;
      mif.out_ren     = 1'b0;
      mif.out_wen     = 1'b0;
      mif.out_addr    = '0;
      mif.out_byte_en = mif.req_byte_en[grant_q*BE_W +: BE_W];
      mif.out_wdata   = swap(mif.req_wdata[grant_q*DATA_W +: DATA_W]);
      mif.req_busy    = '1;
      case (state_q)
         IDLE: begin
            if (any_active) begin
               grant_d = winner;
               state_d = REQ;
            end
         end
         REQ: begin
            // A write wins over a simultaneous read; a dropped request aborts with no bus strobe.
            mif.out_wen  = mif.req_wen[grant_q];
            mif.out_ren  = mif.req_ren[grant_q] & ~mif.req_wen[grant_q];
            mif.out_addr = mif.req_addr[grant_q*ADDR_W +: ADDR_W];
            state_d      = active[grant_q] ? WAIT : IDLE;
         end
         WAIT: begin
            mif.req_busy[grant_q] = mif.out_busy;
            if (!mif.out_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mif.req_rdata = swap(mif.out_rdata);

   always_ff @(posedge CLK) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!nRST) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end
endmodule

// File: doc/multi_port_mem_arbiter.md
Name: multi_port_mem_arbiter

Overview:
- N-channel generalisation of the core memory controller. Arbitrates any number of generic-bus masters (I-fetch, D-access, debug, DMA, ...) onto one generic-bus slave port, which is normally the AHB/bus master.
- Each transaction follows a fixed sequence: a one-cycle request phase, a wait phase, then a single-cycle completion.
- The grant is held for the whole transaction. Optional endian swap on the shared data path.

Parameters:
- NUM_CH, 2: number of requesting channels (≥2); channel 0 is highest fixed priority.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- LITTLE_ENDIAN, 1: 1 = byte-swap wdata and rdata between channels and bus; 0 = pass through.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low
- req_ren  in  NUM_CH  per-channel read request
- req_wen  in  NUM_CH  per-channel write request
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  per-channel write data
- req_byte_en  in  NUM_CH*DATA_W/8  per-channel byte enables
- req_busy  out  NUM_CH  per-channel busy; low for exactly one cycle at completion
- req_rdata  out  DATA_W  read data, shared by all channels
- out_ren  out  1  bus read
- out_wen  out  1  bus write
- out_addr  out  ADDR_W  bus address
- out_wdata  out  DATA_W  bus write data
- out_byte_en  out  DATA_W/8  bus byte enables
- out_busy  in  1  bus busy; low means the transfer is done
- out_rdata  in  DATA_W  bus read data

Behaviour:
- States: IDLE, REQ, WAIT. Registers: state, grant_q (index), rr_ptr (index).
- Reset (nRST low at a CLK edge):
  - state=IDLE, grant_q=0, rr_ptr=0.
  - Outputs then: out_ren/out_wen/out_addr=0, req_busy=all 1s.
- A channel is active when req_ren[i] | req_wen[i]. If both are set, the access is a write; out_ren is forced 0.
- IDLE:
  - Outputs idle: out_ren=out_wen=0, out_addr=0, all req_busy=1.
  - If any channel is active: pick a winner, register it in grant_q, go to REQ.
  - Otherwise stay in IDLE.
- REQ (exactly one cycle):
  - Drive out_ren/out_wen/out_addr/out_byte_en from channel grant_q; all req_busy=1.
  - If channel grant_q is no longer active (abort, e.g. interrupt flush): go to IDLE. No bus request is issued because out_ren=out_wen=0 that cycle.
  - Otherwise go to WAIT.
- WAIT:
  - out_ren=out_wen=0, out_addr=0.
  - out_byte_en and out_wdata still come from grant_q (data phase).
  - req_busy[grant_q]=out_busy; all other req_busy=1.
  - When out_busy=0: completion; go to IDLE. Otherwise stay in WAIT.
  - Requester deassertion during WAIT does not cancel the transaction; the grant is held until out_busy=0.
- out_wdata is the (optionally swapped) req_wdata of grant_q in every state. req_rdata is the (optionally swapped) out_rdata, combinational, in every state.
- Latency: a request seen in IDLE at cycle t appears on out_* at t+1. The earliest completion (req_busy low) is t+2. Back-to-back throughput is 3 cycles per transfer.
- Fixed priority (macro absent): the lowest active index wins.
- Simultaneous events:
  - A new request that arrives while the arbiter is in REQ or WAIT waits; it is evaluated in the next IDLE.
  - A request that deasserts before it is granted is dropped silently.
- Reset mid-transaction: the FSM returns to IDLE at once. Any outstanding bus transfer is abandoned; the bus must be reset at the same time.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - The winner is the first active channel searching upward from rr_ptr, with wrap-around.
  - On each IDLE→REQ transition, rr_ptr is set to (winner+1) mod NUM_CH.
  - An aborted REQ still advances rr_ptr.
- Undefined: fixed priority as above; rr_ptr is not implemented (held at 0).

Test Plan:
- Single read, NUM_CH=2: ch1 ren, addr=0x100, bus busy for 2 cycles in WAIT, out_rdata=0x11223344 -> out_ren=1 and out_addr=0x100 for one cycle; req_busy[1] low for one cycle; req_rdata=0x44332211 (LITTLE_ENDIAN=1).
- Write, both channels requesting, fixed priority: ch0 wen addr=0x200 wdata=0xAABBCCDD, ch1 ren, same cycle -> ch0 is serviced first with out_wen=1; ch1's read is issued 3 cycles later; req_busy[1] stays 1 throughout ch0's transfer.
- Round robin (MEM_ARB_ROUND_ROBIN_EN, NUM_CH=4): channels 0–3 all hold requests -> grant order 0,1,2,3,0; each completion is one cycle of req_busy low on the granted channel only.
- Abort: ch0 ren asserted in IDLE, deasserted in the REQ cycle -> out_ren=0 throughout; FSM returns to IDLE; no req_busy pulse.
- Hold during WAIT: ch1 drops ren in WAIT while out_busy=1 -> the FSM stays in WAIT until out_busy=0, then completes normally.
- Reset mid-WAIT: nRST low for one edge -> state=IDLE, all req_busy=1, out_ren=out_wen=0 on the next cycle.
